bit_deserializer8: RTL and testbench

//  Serial-to-parallel collector: accepts one data bit per handshake on `in` and

---
 rtl/bit_deserializer8.sv | 182 ++++++++++++++++++
 tb/tb_bit_deserializer8.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer8.sv
// ----------------------------------------------------------------------------
// bit_deserializer8
//
// Serial-to-parallel collector. One data bit is accepted per valid/ready
// handshake on the serial side. Bits are assembled into a WIDTH-bit word, and
// the finished word is presented on a registered valid/ready output port. It
// sits between a bit-serial source and word-wide datapath logic, such as the
// 8-way reduction and mux gates that consume 8-bit buses.
//
// Parameters
//   WIDTH      bits per assembled word (>= 2)
//   MSB_FIRST  0: first accepted bit lands in out[0]
//              1: first accepted bit lands in out[WIDTH-1]
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (synchronous release expected)
//   in         serial data bit
//   in_valid   'in' carries a bit this cycle
//   in_ready   block accepts 'in' this cycle. This is combinational from
//              out_ready.
//   out        assembled word (registered)
//   out_valid  'out' holds a word that has not been consumed
//   out_ready  sink consumes 'out' this cycle
//   bit_cnt    number of bits already collected toward the next word
//   out_any    (only with ANY_FLAG_EN) OR-reduction of the word, registered
//              together with 'out'
//
// Build option
//   ANY_FLAG_EN  When this macro is defined, the out_any port and its
//                register are added. When it is undefined, both are absent.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module bit_deserializer8 #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
`ifdef ANY_FLAG_EN
   ,
   output logic                     out_any
`endif
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [WIDTH-1:0]  shift_reg;
   logic [WIDTH-1:0]  word_nxt;
   logic              last_bit;
   logic              accept;
   logic              load;
   logic              drain;

   // Returns 'word' with bit 'b' written at the position that belongs to
   // the idx-th accepted bit. The bit order is chosen by MSB_FIRST.
   function automatic logic [WIDTH-1:0] place_bit(
      input logic [WIDTH-1:0] word,
      input logic [CW-1:0]    idx,
      input logic             b
   );
      logic [WIDTH-1:0] w;
      logic [CW-1:0]    pos;
      w   = word;
      pos = MSB_FIRST ? (LAST_IDX - idx) : idx;
      w[pos] = b;
      return w;
   endfunction

   // ---- handshake decode --------------------------------------------------
   assign last_bit = (bit_cnt == LAST_IDX);

   // Only the completing bit is held back, and only while the previous word
   // is still waiting. The earlier bits go into shift_reg and never disturb
   // 'out'. This lets a new word build up while the sink is slow.
   assign in_ready = !(last_bit && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;
   assign load     = accept && last_bit;
   assign drain    = out_valid && out_ready;
   assign word_nxt = place_bit(shift_reg, bit_cnt, in);

   // ---- stage boundary: collect bits / load word --------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
         out       <= '0;
         out_valid <= 1'b0;
`ifdef ANY_FLAG_EN
         out_any   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            if (last_bit) begin
               // The finished word moves to the output. The collector is
               // cleared, so the next word starts from all zeros.
               bit_cnt   <= '0;
               shift_reg <= '0;
               out       <= word_nxt;
`ifdef ANY_FLAG_EN
               out_any   <= |word_nxt;
`endif
            end else begin
               bit_cnt   <= bit_cnt + CW'(1);
               shift_reg <= word_nxt;
            end
         end

         // If a load and a drain happen on the same edge, the load wins.
         // The old word is consumed, the new word replaces it, and no
         // invalid cycle appears in between.
         if (load) begin
            out_valid <= 1'b1;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

   // ---- control FSM: state register ---------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- control FSM: next state -------------------------------------------
   // IDLE  : no bits are collected yet.
   // SHIFT : a word is partly collected, or its last bit can still go in.
   // STALL : the last bit is held back by a word that is still pending.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // WIDTH >= 2, so the first bit can never complete a word.
            if (accept) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (load) begin
               state_nxt = IDLE;
            end else if (last_bit && !in_ready) begin
               state_nxt = STALL;
            end
         end
         STALL: begin
            if (load) begin
               state_nxt = IDLE;
            end else if (in_ready) begin
               // The sink drained, but no bit was offered. The last bit is
               // now free to enter, so the FSM goes back to collecting.
               state_nxt = SHIFT;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bit_deserializer8.sv
`timescale 1ns/1ps

module tb_bit_deserializer8;

   logic       clk = 1'b0;
   logic       reset;
   logic       in;
   logic       in_valid;
   logic       out_ready;

   logic       in_ready_l, out_valid_l;
   logic [7:0] out_l;
   logic [2:0] cnt_l;
   logic       in_ready_m, out_valid_m;
   logic [7:0] out_m;
   logic [2:0] cnt_m;
`ifdef ANY_FLAG_EN
   logic       any_l, any_m;
`endif

   always #5 clk = ~clk;

   bit_deserializer8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .in_ready(in_ready_l), .out(out_l), .out_valid(out_valid_l),
      .out_ready(out_ready), .bit_cnt(cnt_l)
`ifdef ANY_FLAG_EN
      , .out_any(any_l)
`endif
   );

   bit_deserializer8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .in_ready(in_ready_m), .out(out_m), .out_valid(out_valid_m),
      .out_ready(out_ready), .bit_cnt(cnt_m)
`ifdef ANY_FLAG_EN
      , .out_any(any_m)
`endif
   );

   typedef struct {
      logic [7:0] word;
      logic       any;
   } exp_t;

   typedef struct {
      logic [7:0] seq;     // bit k is the k-th bit sent
      logic [7:0] exp_l;   // expected word, LSB-first instance
      logic [7:0] exp_m;   // expected word, MSB-first instance
      logic       exp_any;
   } vec_t;

   exp_t q_l[$];
   exp_t q_m[$];
   exp_t e_l, e_m;
   vec_t vecs[7];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard: a word is popped and compared whenever a handshake is
   // about to happen at the next rising edge.
   always @(negedge clk) begin
      if (reset === 1'b0 && out_ready === 1'b1) begin
         if (out_valid_l === 1'b1) begin
            if (q_l.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_l_unexpected actual=%0h required=none", out_l);
            end else begin
               e_l = q_l.pop_front();
               check("sb_l_word", out_l, e_l.word);
`ifdef ANY_FLAG_EN
               check("sb_l_any", any_l, e_l.any);
`endif
            end
         end
         if (out_valid_m === 1'b1) begin
            if (q_m.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_m_unexpected actual=%0h required=none", out_m);
            end else begin
               e_m = q_m.pop_front();
               check("sb_m_word", out_m, e_m.word);
`ifdef ANY_FLAG_EN
               check("sb_m_any", any_m, e_m.any);
`endif
            end
         end
      end
   end

   // Drive bits seq[first..last]. Each bit is held for one cycle. When the
   // completing bit is driven, the expected word is queued.
   task automatic send_bits(input logic [7:0] seq, input int first, input int last,
                            input logic [7:0] el, input logic [7:0] em, input logic ea);
      logic [7:0] s;
      s = seq;
      for (int k = first; k <= last; k++) begin
         in       = s[k];
         in_valid = 1'b1;
         check("bit_cnt_l", cnt_l, k);
         check("bit_cnt_m", cnt_m, k);
         if (k < 7 || out_ready) begin
            check("in_ready_l", in_ready_l, 1);
            check("in_ready_m", in_ready_m, 1);
         end
         if (k == 7) begin
            q_l.push_back('{word: el, any: ea});
            q_m.push_back('{word: em, any: ea});
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{seq: 8'h26, exp_l: 8'h26, exp_m: 8'h64, exp_any: 1'b1}; // 0,1,1,0,0,1,0,0
      vecs[1] = '{seq: 8'h00, exp_l: 8'h00, exp_m: 8'h00, exp_any: 1'b0};
      vecs[2] = '{seq: 8'hA5, exp_l: 8'hA5, exp_m: 8'hA5, exp_any: 1'b1};
      vecs[3] = '{seq: 8'h80, exp_l: 8'h80, exp_m: 8'h01, exp_any: 1'b1};
      vecs[4] = '{seq: 8'h08, exp_l: 8'h08, exp_m: 8'h10, exp_any: 1'b1}; // 0,0,0,1,0,0,0,0
      vecs[5] = '{seq: 8'h01, exp_l: 8'h01, exp_m: 8'h80, exp_any: 1'b1};
      vecs[6] = '{seq: 8'h35, exp_l: 8'h35, exp_m: 8'hAC, exp_any: 1'b1};

      reset     = 1'b1;
      in        = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Reset is held while the inputs toggle.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_valid = ~in_valid;
         in       = ~in;
      end
      check("rst_out_l", out_l, 0);
      check("rst_valid_l", out_valid_l, 0);
      check("rst_cnt_l", cnt_l, 0);
      check("rst_ready_l", in_ready_l, 1);
      check("rst_out_m", out_m, 0);
      check("rst_valid_m", out_valid_m, 0);
      check("rst_cnt_m", cnt_m, 0);
      check("rst_ready_m", in_ready_m, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk); #1;

      // Table vectors, sent back to back with the sink always ready.
      for (int i = 0; i < 7; i++) begin
         send_bits(vecs[i].seq, 0, 7, vecs[i].exp_l, vecs[i].exp_m, vecs[i].exp_any);
         check("word_valid_l", out_valid_l, 1);
         check("word_out_l", out_l, vecs[i].exp_l);
         check("word_out_m", out_m, vecs[i].exp_m);
         check("word_cnt_l", cnt_l, 0);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("drained_valid_l", out_valid_l, 0);
      check("drained_valid_m", out_valid_m, 0);

      // Back-pressure: a pending word blocks only the completing bit.
      out_ready = 1'b0;
      send_bits(8'hFF, 0, 7, 8'hFF, 8'hFF, 1'b1);
      send_bits(8'h12, 0, 6, 8'h00, 8'h00, 1'b0);
      in       = 1'b0;          // bit 7 of 8'h12
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("stall_ready_l", in_ready_l, 0);
         check("stall_ready_m", in_ready_m, 0);
         check("stall_cnt_l", cnt_l, 7);
         check("stall_out_l", out_l, 8'hFF);
         check("stall_out_m", out_m, 8'hFF);
         check("stall_valid_l", out_valid_l, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      check("unstall_ready_l", in_ready_l, 1);
      check("unstall_ready_m", in_ready_m, 1);
      q_l.push_back('{word: 8'h12, any: 1'b1});
      q_m.push_back('{word: 8'h48, any: 1'b1});
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("nobubble_valid_l", out_valid_l, 1);
      check("nobubble_out_l", out_l, 8'h12);
      check("nobubble_out_m", out_m, 8'h48);
      check("nobubble_cnt_l", cnt_l, 0);
      @(posedge clk); #1;
      check("after_stall_valid_l", out_valid_l, 0);

      // Idle cycles in the middle of a word keep the partial bits.
      send_bits(8'hC9, 0, 2, 8'h00, 8'h00, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in = ~in;
         @(posedge clk); #1;
      end
      check("idle_cnt_l", cnt_l, 3);
      check("idle_cnt_m", cnt_m, 3);
      send_bits(8'hC9, 3, 7, 8'hC9, 8'h93, 1'b1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Reset in the middle of a word discards the partial bits.
      send_bits(8'h1F, 0, 4, 8'h00, 8'h00, 1'b0);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("midrst_cnt_l", cnt_l, 0);
      check("midrst_cnt_m", cnt_m, 0);
      check("midrst_out_l", out_l, 0);
      check("midrst_valid_l", out_valid_l, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      send_bits(8'h01, 0, 7, 8'h01, 8'h80, 1'b1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      check("sb_l_left", q_l.size(), 0);
      check("sb_m_left", q_m.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
